// File: rtl/uart_arb_pkg.sv
// Shared types and defaults for the UART TX write-port arbiter.
// Width helpers keep the top and the picker in agreement.
package uart_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } arb_state_e;

  localparam int NREQ_DEF     = 4;
  localparam int DWIDTH_DEF   = 8;
  localparam int MAXBURST_DEF = 16;
  localparam int TIMEOUT_DEF  = 64;

  // Grant index width; never below one bit
  function automatic int gw_f(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Byte counter width, must hold MAXBURST itself
  function automatic int cw_f(input int m);
    return $clog2(m + 1);
  endfunction

  localparam int GW = gw_f(NREQ_DEF);
  localparam int CW = cw_f(MAXBURST_DEF);

endpackage

// File: rtl/uart_rr_pick.sv
// Rotating-priority encoder: first set request at or above ptr,
// wrapping modulo NREQ. Shared with the RX-side demultiplexer.
module uart_rr_pick #(
  parameter int NREQ = 4,
  parameter int GW   = 2
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [GW-1:0]   ptr_i,
  output logic [GW-1:0]   win_o,
  output logic            any_o
);

  int idx;

  // Scan downward so the lowest rotated offset wins last
  always_comb begin
    win_o = '0;
    idx   = 0;
    any_o = |req_i;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = int'(ptr_i) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (req_i[idx]) win_o = GW'(idx);
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-granular round-robin arbiter for the UART TX FIFO port.
// Grant held per packet, with burst cap and idle timeout.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int NREQ     = NREQ_DEF,
  parameter int DWIDTH   = DWIDTH_DEF,
  parameter int MAXBURST = MAXBURST_DEF,
  parameter int TIMEOUT  = TIMEOUT_DEF
) (
  input  logic                   HCLK,
  input  logic                   HRESET,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [NREQ*DWIDTH-1:0] req_data,
  input  logic [NREQ-1:0]        req_last,
  output logic [NREQ-1:0]        req_ready,
  input  logic                   fifo_full,
  output logic                   fifo_wr,
  output logic [DWIDTH-1:0]      fifo_wdata,
  output logic [gw_f(NREQ)-1:0]  grant_id,
  output logic                   busy,
  output logic                   timeout_evt
);

  localparam int GW = gw_f(NREQ);
  localparam int CW = cw_f(MAXBURST);

  arb_state_e        state_q;
  logic [GW-1:0]     rr_ptr_q;
  logic [GW-1:0]     rr_ptr_d;
  logic [GW-1:0]     grant_q;
  logic [GW-1:0]     pick_idx;
  logic [CW-1:0]     byte_cnt_q;
  logic [CW-1:0]     byte_cnt_d;
  logic [7:0]        idle_cnt_q;
  logic [7:0]        idle_cnt_d;
  logic              busy_q;
  logic              tevt_q;
  logic              any_valid;
  logic              in_xfer;
  logic              sel_valid;
  logic              sel_last;
  logic              xfer;
  logic              rel_xfer;
  logic              rel_tout;
  logic [DWIDTH-1:0] sel_data;

  uart_rr_pick #(
    .NREQ (NREQ),
    .GW   (GW)
  ) u_pick (
    .req_i (req_valid),
    .ptr_i (rr_ptr_q),
    .win_o (pick_idx),
    .any_o (any_valid)
  );

  // Grantee mux, handshake and release conditions
  always_comb begin
    sel_valid  = req_valid[grant_q];
    sel_last   = req_last[grant_q];
    sel_data   = req_data[int'(grant_q)*DWIDTH +: DWIDTH];
    in_xfer    = (state_q == XFER) && !HRESET;
    xfer       = in_xfer && sel_valid && !fifo_full;
    byte_cnt_d = byte_cnt_q + CW'(1);
    idle_cnt_d = idle_cnt_q + 8'd1;
    rel_xfer   = xfer &&
                 (sel_last || (byte_cnt_d == CW'(MAXBURST)));
    rel_tout   = in_xfer && !sel_valid &&
                 (idle_cnt_d == 8'(TIMEOUT));
    rr_ptr_d   = (grant_q == GW'(NREQ - 1)) ?
                 '0 : grant_q + GW'(1);
    req_ready  = '0;
    if (in_xfer && !fifo_full) req_ready[grant_q] = 1'b1;
    fifo_wr    = xfer;
    fifo_wdata = xfer ? sel_data : '0;
  end

  // Arbitration FSM with counters and registered status
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      grant_q    <= '0;
      byte_cnt_q <= '0;
      idle_cnt_q <= '0;
      busy_q     <= 1'b0;
      tevt_q     <= 1'b0;
    end else begin
      tevt_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (any_valid) begin
            state_q    <= XFER;
            grant_q    <= pick_idx;
            byte_cnt_q <= '0;
            idle_cnt_q <= '0;
            busy_q     <= 1'b1;
          end
        end
        XFER: begin
          if (xfer) begin
            byte_cnt_q <= byte_cnt_d;
            idle_cnt_q <= '0;
          end else if (!sel_valid) begin
            idle_cnt_q <= idle_cnt_d;
          end
          if (rel_xfer || rel_tout) begin
            state_q  <= IDLE;
            busy_q   <= 1'b0;
            rr_ptr_q <= rr_ptr_d;
          end
          tevt_q <= rel_tout;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign grant_id    = grant_q;
  assign busy        = busy_q;
  assign timeout_evt = tevt_q;

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin arbiter that shares the single write port of the UART transmit FIFO between several byte-stream requesters, such as the CPU bus path, a debug monitor and a DMA engine. A requester holds the grant for a whole packet, so bytes from different sources never interleave on the serial line. The arbiter sits between the requesters and the TX FIFO write interface, in front of the transmitter.

## Interface
Parameters:
- NREQ, 4: number of requesters (2..8).
- DWIDTH, 8: byte width; matches the TX FIFO data width.
- MAXBURST, 16: maximum bytes per grant before forced rotation (1..256).
- TIMEOUT, 64: idle cycles with a grant held and no valid before forced release (1..255).

Ports (name, direction, width, meaning):
- HCLK, in, 1: the single clock.
- HRESET, in, 1: synchronous, active-high reset.
- req_valid, in, NREQ: per-requester byte valid.
- req_data, in, NREQ*DWIDTH: requester i drives bits [i*DWIDTH +: DWIDTH].
- req_last, in, NREQ: the byte on this requester is the last of its packet.
- req_ready, out, NREQ: per-requester accept; at most one bit set.
- fifo_full, in, 1: TX FIFO full flag.
- fifo_wr, out, 1: TX FIFO write strobe.
- fifo_wdata, out, DWIDTH: TX FIFO write data.
- grant_id, out, clog2(NREQ): index of the current or most recent grantee.
- busy, out, 1: a grant is held (state XFER).
- timeout_evt, out, 1: one-cycle pulse when a grant is released by timeout.

## Operation
- State machine has two states: IDLE and XFER.
- IDLE:
  - If any req_valid is set, pick the first set bit scanning upward from rr_ptr, wrapping modulo NREQ.
  - Register that index in grant_id, clear byte_cnt and idle_cnt, and go to XFER.
  - If no req_valid is set, stay in IDLE.
- XFER:
  - req_ready[grant_id] = !fifo_full. All other req_ready bits are 0.
  - A byte transfers when req_valid[g] && req_ready[g].
  - On a transfer: fifo_wr=1 and fifo_wdata=req_data[g], combinationally in the same cycle. byte_cnt increments and idle_cnt clears.
  - No transfer because the FIFO is full: idle_cnt holds. A full FIFO is backpressure, not idleness.
  - No transfer because req_valid[g]=0: idle_cnt increments.
- Release, from XFER to IDLE, with rr_ptr set to (g+1) mod NREQ. Any one of:
  - The transfer carries req_last.
  - The transfer makes byte_cnt reach MAXBURST.
  - idle_cnt reaches TIMEOUT; timeout_evt pulses in that cycle.
- Forced rotation at MAXBURST does not end the packet. The requester re-arbitrates and its remaining bytes follow its next grant.
- Outside XFER: fifo_wr=0 and fifo_wdata=0.
- Reset values: state IDLE, rr_ptr 0, grant_id 0, byte_cnt 0, idle_cnt 0, and all outputs 0.
- Reset asserted mid-burst returns to IDLE in the next cycle. A byte presented in the reset cycle is not written.

## Timing
- Arbitration latency is 1 cycle: valid seen in IDLE at cycle n, so req_ready can first be high at n+1.
- Steady throughput is 1 byte per cycle while valid=1 and fifo_full=0.
- Release cycle to the next grant:
  - The release cycle is XFER, the next cycle is IDLE, and the new grantee's first byte is accepted one cycle later.
  - This gives 1 dead cycle between grants.
- fifo_wr depends combinationally on fifo_full and req_valid. There is no registered path, so the FIFO must not be written in a cycle where it is full.
- Simultaneous last byte and fifo_full=1: no transfer and no release. The grant is held until the byte is accepted.
- byte_cnt is clog2(MAXBURST+1) bits and idle_cnt is 8 bits. Neither wraps; both clear on grant.

## Structure
- Package uart_arb_pkg holds:
  - The state enum (IDLE, XFER).
  - Default localparams: NREQ, DWIDTH, MAXBURST, TIMEOUT.
  - Width helpers: GW = clog2(NREQ) and CW = clog2(MAXBURST+1).
- Sub-module uart_rr_pick: combinational rotating-priority encoder.
  - Inputs: req vector and rr_ptr.
  - Outputs: winning index and any_valid.
  - Reused by the planned RX-side demultiplexer.

## Test plan
- Single requester 2 sends 3 bytes 0x41, 0x42, 0x43 with last on 0x43.
  - fifo_wr asserts on 3 consecutive cycles starting 1 cycle after valid, with the same data in order.
  - grant_id=2, then rr_ptr=3.
- Requesters 0 and 1 both valid from reset, each sending a 2-byte packet.
  - Write order is 0a, 0b, then a dead cycle, then 1a, 1b. No interleave.
- MAXBURST=4, requester 0 sends 6 bytes while requester 3 also requests.
  - Requester 0 sends 4 bytes, requester 3 gets its packet next, then requester 0 sends its remaining 2 bytes.
- fifo_full held high for 10 cycles mid-packet.
  - req_ready=0 and fifo_wr=0 throughout, no timeout_evt.
  - The packet resumes with the next byte intact.
- Requester 1 drops valid after 1 byte with TIMEOUT=5.
  - timeout_evt pulses exactly 5 cycles later, busy=0, and a waiting requester 2 is granted the following cycle.
- HRESET asserted during byte 2 of a 4-byte burst.
  - Next cycle: busy=0, grant_id=0, fifo_wr=0.
  - The next arbitration starts from requester 0.
